// File: rtl/dmi_router_pkg.sv
// dmi_router_pkg
//   Shared definitions for the DMI router:
//   - DMI_ADDR_W / DMI_DATA_W : DMI address and data widths
//   - CORE_TOP_DEF            : default highest address of the core aperture
//   - sel_e                   : read-data source selector (CORE, TGT0..TGT3, NONE)
//   - tgt_sel()               : maps a target index to its selector value
package dmi_router_pkg;

  localparam int unsigned DMI_ADDR_W = 7;
  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [DMI_ADDR_W-1:0] CORE_TOP_DEF = 7'h4F;

  typedef enum logic [2:0] {
    SEL_CORE = 3'd0,
    SEL_TGT0 = 3'd1,
    SEL_TGT1 = 3'd2,
    SEL_TGT2 = 3'd3,
    SEL_TGT3 = 3'd4,
    SEL_NONE = 3'd5
  } sel_e;

  // Target selector values are contiguous, starting right after SEL_CORE.
  function automatic sel_e tgt_sel(input int idx);
    return sel_e'(3'(idx + 1));
  endfunction

endpackage

// File: rtl/dmi_router_dec.sv
// dmi_router_dec
//   Combinational DMI address decoder. Produces a one-hot hit vector over
//   {core, targets, none}.
//   Parameters: NUM_TGT, TGT_BASE (packed ascending bases, entry 0 in LSBs),
//               CORE_TOP (highest core address).
//   Ports:
//     addr     in   DMI address
//     en_s     in   synchronised uncore permission
//     core_hit out  address is in the core aperture
//     tgt_hit  out  per-target hit, already gated by en_s
//     none_hit out  no permitted destination (gap region or blocked target)
module dmi_router_dec
  import dmi_router_pkg::*;
#(
  parameter int unsigned                       NUM_TGT  = 2,
  parameter logic [NUM_TGT*DMI_ADDR_W-1:0]     TGT_BASE = {7'h60, 7'h50},
  parameter logic [DMI_ADDR_W-1:0]             CORE_TOP = CORE_TOP_DEF
) (
  input  logic [DMI_ADDR_W-1:0] addr,
  input  logic                  en_s,
  output logic                  core_hit,
  output logic [NUM_TGT-1:0]    tgt_hit,
  output logic                  none_hit
);

  logic [NUM_TGT-1:0] tgt_raw;

  always_comb begin
    core_hit = (addr <= CORE_TOP);
    tgt_raw  = '0;
    // Ascending scan: the last base that the address clears wins, which is
    // the highest matching target.
    if (!core_hit) begin
      for (int i = 0; i < int'(NUM_TGT); i++) begin
        if (addr >= TGT_BASE[i*DMI_ADDR_W +: DMI_ADDR_W]) begin
          tgt_raw    = '0;
          tgt_raw[i] = 1'b1;
        end
      end
    end
    // A target hit without uncore permission degrades to "no destination".
    tgt_hit  = en_s ? tgt_raw : '0;
    none_hit = !core_hit && (tgt_hit == '0);
  end

endmodule

// File: rtl/dmi_router.sv
// dmi_router
//   Routes single-cycle DMI accesses to the core or to one of NUM_TGT uncore
//   targets, and returns the read data of the last accepted access.
//   Optional feature: define DMI_ROUTER_ERR_EN to get a sticky access-error
//   flag (set by any access with no permitted destination, cleared by
//   dmi_err_clr, set wins). Undefined: dmi_err is constant 0.
//   Ports:
//     clk, rst_l                  clock, asynchronous active-low reset
//     uncore_enable               uncore permission (asynchronous to clk)
//     dmi_en/dmi_wr_en            access strobe / write qualifier
//     dmi_addr/dmi_wdata          access address / write data
//     dmi_rdata                   read data of the last accepted access
//     dmi_core_*                  core strobes, pass-through addr/data, rdata
//     dmi_tgt_*                   per-target strobes, shared addr/data,
//                                 packed per-target rdata (target 0 in LSBs)
//     dmi_err_clr/dmi_err         sticky error clear / flag
module dmi_router
  import dmi_router_pkg::*;
#(
  parameter int unsigned                       NUM_TGT  = 2,
  parameter logic [NUM_TGT*DMI_ADDR_W-1:0]     TGT_BASE = {7'h60, 7'h50},
  parameter logic [DMI_ADDR_W-1:0]             CORE_TOP = CORE_TOP_DEF
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          uncore_enable,
  input  logic                          dmi_en,
  input  logic                          dmi_wr_en,
  input  logic [DMI_ADDR_W-1:0]         dmi_addr,
  input  logic [DMI_DATA_W-1:0]         dmi_wdata,
  output logic [DMI_DATA_W-1:0]         dmi_rdata,
  output logic                          dmi_core_en,
  output logic                          dmi_core_wr_en,
  output logic [DMI_ADDR_W-1:0]         dmi_core_addr,
  output logic [DMI_DATA_W-1:0]         dmi_core_wdata,
  input  logic [DMI_DATA_W-1:0]         dmi_core_rdata,
  output logic [NUM_TGT-1:0]            dmi_tgt_en,
  output logic [NUM_TGT-1:0]            dmi_tgt_wr_en,
  output logic [DMI_ADDR_W-1:0]         dmi_tgt_addr,
  output logic [DMI_DATA_W-1:0]         dmi_tgt_wdata,
  input  logic [NUM_TGT*DMI_DATA_W-1:0] dmi_tgt_rdata,
  input  logic                          dmi_err_clr,
  output logic                          dmi_err
);

  // Two-flop synchroniser for the asynchronous uncore permission.
  logic [1:0] sync_q, sync_d;
  logic       en_s;

  logic               core_hit;
  logic [NUM_TGT-1:0] tgt_hit;
  logic               none_hit;

  sel_e sel_q, sel_d;
  logic [DMI_DATA_W-1:0] rdata_mux;

  dmi_router_dec #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .CORE_TOP (CORE_TOP)
  ) u_dec (
    .addr     (dmi_addr),
    .en_s     (en_s),
    .core_hit (core_hit),
    .tgt_hit  (tgt_hit),
    .none_hit (none_hit)
  );

  assign en_s = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], uncore_enable};
  end

  // Strobes are purely combinational; address and data fan out unchanged.
  assign dmi_core_en    = dmi_en & core_hit;
  assign dmi_core_wr_en = dmi_en & dmi_wr_en & core_hit;
  assign dmi_tgt_en     = {NUM_TGT{dmi_en}} & tgt_hit;
  assign dmi_tgt_wr_en  = {NUM_TGT{dmi_en & dmi_wr_en}} & tgt_hit;
  assign dmi_core_addr  = dmi_addr;
  assign dmi_core_wdata = dmi_wdata;
  assign dmi_tgt_addr   = dmi_addr;
  assign dmi_tgt_wdata  = dmi_wdata;

  // The selector captures where the current access went so read data stays
  // stable after dmi_addr moves on.
  always_comb begin
    sel_d = sel_q;
    if (dmi_en) begin
      if (core_hit) begin
        sel_d = SEL_CORE;
      end else if (none_hit) begin
        sel_d = SEL_NONE;
      end else begin
        for (int i = 0; i < int'(NUM_TGT); i++) begin
          if (tgt_hit[i]) sel_d = tgt_sel(i);
        end
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (sel_q == SEL_CORE) rdata_mux = dmi_core_rdata;
    for (int i = 0; i < int'(NUM_TGT); i++) begin
      if (sel_q == tgt_sel(i)) rdata_mux = dmi_tgt_rdata[i*DMI_DATA_W +: DMI_DATA_W];
    end
  end

  assign dmi_rdata = rdata_mux;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_q <= '0;
      sel_q  <= SEL_NONE;
    end else begin
      sync_q <= sync_d;
      sel_q  <= sel_d;
    end
  end

`ifdef DMI_ROUTER_ERR_EN
  logic err_q, err_d;

  // Set is applied after clear so a simultaneous error keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (dmi_err_clr)        err_d = 1'b0;
    if (dmi_en && none_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dmi_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = dmi_err_clr;
  assign dmi_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_router.sv
// tb_dmi_router
//   Self-checking bench for dmi_router. Instantiates the router with two
//   targets based at 0x53 and 0x60 so that the core aperture (<=0x4F), a gap
//   (0x50..0x52) and both targets are all reachable. Expected values come
//   from a behavioural model: an address-range decode function, a two-deep
//   delay line for the uncore permission, and the recorded destination of
//   the last accepted access.
module tb_dmi_router;

  localparam int          NT   = 2;
  localparam logic [13:0] BASE = {7'h60, 7'h53};
  localparam logic [6:0]  CTOP = 7'h4F;

`ifdef DMI_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_l;
  logic           uncore_enable;
  logic           dmi_en;
  logic           dmi_wr_en;
  logic [6:0]     dmi_addr;
  logic [31:0]    dmi_wdata;
  logic [31:0]    dmi_rdata;
  logic           dmi_core_en;
  logic           dmi_core_wr_en;
  logic [6:0]     dmi_core_addr;
  logic [31:0]    dmi_core_wdata;
  logic [31:0]    dmi_core_rdata;
  logic [NT-1:0]  dmi_tgt_en;
  logic [NT-1:0]  dmi_tgt_wr_en;
  logic [6:0]     dmi_tgt_addr;
  logic [31:0]    dmi_tgt_wdata;
  logic [NT*32-1:0] dmi_tgt_rdata;
  logic           dmi_err_clr;
  logic           dmi_err;

  dmi_router #(
    .NUM_TGT  (NT),
    .TGT_BASE (BASE),
    .CORE_TOP (CTOP)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .uncore_enable  (uncore_enable),
    .dmi_en         (dmi_en),
    .dmi_wr_en      (dmi_wr_en),
    .dmi_addr       (dmi_addr),
    .dmi_wdata      (dmi_wdata),
    .dmi_rdata      (dmi_rdata),
    .dmi_core_en    (dmi_core_en),
    .dmi_core_wr_en (dmi_core_wr_en),
    .dmi_core_addr  (dmi_core_addr),
    .dmi_core_wdata (dmi_core_wdata),
    .dmi_core_rdata (dmi_core_rdata),
    .dmi_tgt_en     (dmi_tgt_en),
    .dmi_tgt_wr_en  (dmi_tgt_wr_en),
    .dmi_tgt_addr   (dmi_tgt_addr),
    .dmi_tgt_wdata  (dmi_tgt_wdata),
    .dmi_tgt_rdata  (dmi_tgt_rdata),
    .dmi_err_clr    (dmi_err_clr),
    .dmi_err        (dmi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: destination of last access (0 core, 1..NT target, -1 none),
  // the two most recent edge samples of uncore_enable, and the error flag.
  int m_sel = -1;
  bit m_s1  = 1'b0;
  bit m_ens = 1'b0;
  bit m_err = 1'b0;

  // Per-cycle observed and expected values filled in by cyc().
  logic          o_core_en, o_core_wr, e_core_en, e_core_wr;
  logic [NT-1:0] o_tgt_en, o_tgt_wr, e_tgt_en, e_tgt_wr;
  logic [31:0]   o_rdata, e_rdata, o_wdata;
  logic          o_err, e_err, o_pass;

  function automatic int decode(input logic [6:0] a);
    if (a <= CTOP) return 0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (a >= BASE[i*7 +: 7]) return i + 1;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input int sel);
    if (sel == 0) return dmi_core_rdata;
    if (sel > 0)  return dmi_tgt_rdata[(sel-1)*32 +: 32];
    return 32'h0;
  endfunction

  // One clock of stimulus: drive the access, capture strobes mid-cycle,
  // advance the model across the edge, then capture registered results.
  task automatic cyc(input bit en, input bit wr, input logic [6:0] a,
                     input logic [31:0] wd, input bit clr);
    int d;
    dmi_en = en; dmi_wr_en = wr; dmi_addr = a; dmi_wdata = wd; dmi_err_clr = clr;
    #1;
    d = decode(a);
    if (d > 0 && !m_ens) d = -1;
    e_core_en = en && (d == 0);
    e_core_wr = en && wr && (d == 0);
    e_tgt_en  = '0;
    if (en && d > 0) e_tgt_en[d-1] = 1'b1;
    e_tgt_wr  = wr ? e_tgt_en : '0;
    o_core_en = dmi_core_en;
    o_core_wr = dmi_core_wr_en;
    o_tgt_en  = dmi_tgt_en;
    o_tgt_wr  = dmi_tgt_wr_en;
    o_wdata   = dmi_core_wdata;
    o_pass    = (dmi_core_addr === a) && (dmi_tgt_addr === a) &&
                (dmi_core_wdata === wd) && (dmi_tgt_wdata === wd);
    @(posedge clk);
    if (rst_l) begin
      if (en) m_sel = d;
      if (ERR_EN) begin
        if (en && d == -1) m_err = 1'b1;
        else if (clr)      m_err = 1'b0;
      end
      m_ens = m_s1;
      m_s1  = uncore_enable;
    end
    #1;
    e_rdata = exp_rd(m_sel);
    e_err   = m_err;
    o_rdata = dmi_rdata;
    o_err   = dmi_err;
  endtask

  task automatic model_reset();
    m_sel = -1; m_s1 = 1'b0; m_ens = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0; uncore_enable = 1'b1;
    dmi_en = 1'b1; dmi_wr_en = 1'b0; dmi_addr = 7'h10;
    dmi_core_rdata = 32'h1234_5678; dmi_tgt_rdata = {32'h2222, 32'h1111};
    #1;
    total++; if (dmi_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", dmi_rdata); end
    total++; if (dmi_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", dmi_err); end
    total++; if (dmi_core_en !== 1'b1) begin bad++; $display("FAIL rst_core_en: got %b want 1", dmi_core_en); end
    @(posedge clk); #1;
    dmi_addr = 7'h55; #1;
    total++; if (dmi_tgt_en !== 2'b00) begin bad++; $display("FAIL rst_tgt_blocked: got %b want 00", dmi_tgt_en); end
    total++; if (dmi_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata_hold: got %h want 0", dmi_rdata); end
    uncore_enable = 1'b0; dmi_en = 1'b0;
    @(posedge clk); #1;
    rst_l = 1'b1;
    model_reset();
  endtask

  task automatic test_core_read();
    dmi_core_rdata = 32'hA5A5_0001;
    cyc(1'b1, 1'b0, 7'h10, 32'h0, 1'b0);
    total++; if (o_core_en !== 1'b1) begin bad++; $display("FAIL core_rd_en: got %b want 1", o_core_en); end
    total++; if (o_core_wr !== 1'b0) begin bad++; $display("FAIL core_rd_wr: got %b want 0", o_core_wr); end
    total++; if (o_tgt_en !== 2'b00) begin bad++; $display("FAIL core_rd_tgt: got %b want 00", o_tgt_en); end
    total++; if (o_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL core_rd_data: got %h want a5a50001", o_rdata); end
    cyc(1'b0, 1'b0, 7'h33, 32'h0, 1'b0);
    total++; if (o_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL core_rd_hold: got %h want a5a50001", o_rdata); end
  endtask

  task automatic test_uncore_sync();
    uncore_enable = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    dmi_tgt_rdata = {32'h2222, 32'h1111};
    uncore_enable = 1'b1;
    cyc(1'b1, 1'b0, 7'h58, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b00) begin bad++; $display("FAIL sync_first_blocked: got %b want 00", o_tgt_en); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL sync_first_rdata: got %h want 0", o_rdata); end
    cyc(1'b0, 1'b0, 7'h58, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 7'h58, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b01) begin bad++; $display("FAIL sync_third_strobe: got %b want 01", o_tgt_en); end
    total++; if (o_rdata !== 32'h1111) begin bad++; $display("FAIL sync_third_rdata: got %h want 1111", o_rdata); end
  endtask

  task automatic test_back_to_back();
    dmi_tgt_rdata = {32'h2222, 32'h1111};
    cyc(1'b1, 1'b0, 7'h55, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b01) begin bad++; $display("FAIL b2b_t0_en: got %b want 01", o_tgt_en); end
    total++; if (o_rdata !== 32'h1111) begin bad++; $display("FAIL b2b_t0_rdata: got %h want 1111", o_rdata); end
    cyc(1'b1, 1'b0, 7'h65, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b10) begin bad++; $display("FAIL b2b_t1_en: got %b want 10", o_tgt_en); end
    total++; if (o_rdata !== 32'h2222) begin bad++; $display("FAIL b2b_t1_rdata: got %h want 2222", o_rdata); end
    cyc(1'b1, 1'b1, 7'h7F, 32'h0BAD_F00D, 1'b0);
    total++; if (o_tgt_wr !== 2'b10) begin bad++; $display("FAIL b2b_t1_wr: got %b want 10", o_tgt_wr); end
    total++; if (o_pass !== 1'b1) begin bad++; $display("FAIL b2b_passthru: got %b want 1", o_pass); end
  endtask

  task automatic test_err();
    cyc(1'b1, 1'b0, 7'h52, 32'h0, 1'b0);
    total++; if ({o_core_en, o_tgt_en} !== 3'b000) begin bad++; $display("FAIL err_no_strobe: got %b want 000", {o_core_en, o_tgt_en}); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL err_rdata: got %h want 0", o_rdata); end
    total++; if (o_err !== ERR_EN) begin bad++; $display("FAIL err_set: got %b want %b", o_err, ERR_EN); end
    cyc(1'b1, 1'b0, 7'h51, 32'h0, 1'b1);
    total++; if (o_err !== ERR_EN) begin bad++; $display("FAIL err_set_wins: got %b want %b", o_err, ERR_EN); end
    cyc(1'b0, 1'b0, 7'h00, 32'h0, 1'b1);
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", o_err); end
  endtask

  task automatic test_write_hold();
    dmi_core_rdata = 32'hC0DE_0001;
    cyc(1'b1, 1'b1, 7'h20, 32'hDEAD_BEEF, 1'b0);
    total++; if (o_core_wr !== 1'b1) begin bad++; $display("FAIL wr_core_wr: got %b want 1", o_core_wr); end
    total++; if (o_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", o_wdata); end
    cyc(1'b0, 1'b0, 7'h70, 32'h0, 1'b0);
    total++; if ({o_core_wr, o_core_en, o_tgt_en} !== 4'b0000) begin bad++; $display("FAIL wr_no_restrobe: got %b want 0000", {o_core_wr, o_core_en, o_tgt_en}); end
    total++; if (o_rdata !== 32'hC0DE_0001) begin bad++; $display("FAIL wr_rdata_hold: got %h want c0de0001", o_rdata); end
  endtask

  task automatic test_reset_mid();
    uncore_enable = 1'b1;
    dmi_tgt_rdata = {32'h2222, 32'h1111};
    cyc(1'b1, 1'b0, 7'h52, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 7'h65, 32'h0, 1'b0);
    total++; if (o_rdata !== 32'h2222) begin bad++; $display("FAIL mid_pre_rdata: got %h want 2222", o_rdata); end
    #2 rst_l = 1'b0;
    #1;
    total++; if (dmi_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", dmi_rdata); end
    total++; if (dmi_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", dmi_err); end
    model_reset();
    @(posedge clk); #1;
    rst_l = 1'b1;
    dmi_core_rdata = 32'h0000_0077;
    cyc(1'b1, 1'b0, 7'h10, 32'h0, 1'b0);
    total++; if (o_rdata !== 32'h77) begin bad++; $display("FAIL mid_post_core: got %h want 77", o_rdata); end
    cyc(1'b1, 1'b0, 7'h58, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b00) begin bad++; $display("FAIL mid_post_blocked: got %b want 00", o_tgt_en); end
    total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL mid_post_blk_rdata: got %h want 0", o_rdata); end
    cyc(1'b1, 1'b0, 7'h58, 32'h0, 1'b0);
    total++; if (o_tgt_en !== 2'b01) begin bad++; $display("FAIL mid_post_strobe: got %b want 01", o_tgt_en); end
    total++; if (o_rdata !== 32'h1111) begin bad++; $display("FAIL mid_post_rdata: got %h want 1111", o_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 11) == 0) uncore_enable = ~uncore_enable;
      dmi_core_rdata = $urandom;
      dmi_tgt_rdata  = {$urandom, $urandom};
      cyc(($urandom_range(0, 2) != 0), 1'($urandom), 7'($urandom_range(0, 127)),
          $urandom, ($urandom_range(0, 3) == 0));
      total++; if (o_core_en !== e_core_en) begin bad++; $display("FAIL rnd_core_en[%0d]: got %b want %b", n, o_core_en, e_core_en); end
      total++; if (o_core_wr !== e_core_wr) begin bad++; $display("FAIL rnd_core_wr[%0d]: got %b want %b", n, o_core_wr, e_core_wr); end
      total++; if (o_tgt_en !== e_tgt_en) begin bad++; $display("FAIL rnd_tgt_en[%0d]: got %b want %b", n, o_tgt_en, e_tgt_en); end
      total++; if (o_tgt_wr !== e_tgt_wr) begin bad++; $display("FAIL rnd_tgt_wr[%0d]: got %b want %b", n, o_tgt_wr, e_tgt_wr); end
      total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o_rdata, e_rdata); end
      total++; if (o_err !== e_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n, o_err, e_err); end
      total++; if (o_pass !== 1'b1) begin bad++; $display("FAIL rnd_passthru[%0d]: got %b want 1", n, o_pass); end
    end
  endtask

  initial begin
    rst_l = 1'b0; uncore_enable = 1'b0;
    dmi_en = 1'b0; dmi_wr_en = 1'b0; dmi_addr = '0; dmi_wdata = '0;
    dmi_core_rdata = '0; dmi_tgt_rdata = '0; dmi_err_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_core_read();
    test_uncore_sync();
    test_back_to_back();
    test_err();
    test_write_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
